// File: rtl/dyn_mem_map_cfg_ctrl.sv
// dyn_mem_map_cfg_ctrl: shadow/active mapping-rule store with commit-time TCDM quiesce
// and an outstanding-transaction cap on the upstream-to-address-map path.
module dyn_mem_map_cfg_ctrl #(
  parameter int NUM_MAP_RULES   = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int IDX_WIDTH       = 2,
  parameter int MAX_OUTSTANDING = 8,
  localparam int RULE_W = IDX_WIDTH + 2 * ADDR_WIDTH,
  localparam int SLOT_W = (NUM_MAP_RULES > 1) ? $clog2(NUM_MAP_RULES) : 1,
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            cfg_valid_i,
  output logic                            cfg_ready_o,
  input  logic [SLOT_W-1:0]               cfg_rule_idx_i,
  input  logic [RULE_W-1:0]               cfg_rule_i,
  input  logic                            cfg_commit_i,
  output logic                            cfg_commit_done_o,
  output logic [NUM_MAP_RULES*RULE_W-1:0] rules_o,
  output logic                            rules_valid_o,
  input  logic                            up_req_i,
  output logic                            up_gnt_o,
  output logic                            dn_req_o,
  input  logic                            dn_gnt_i,
  input  logic                            dn_rvalid_i,
  output logic                            busy_o,
  output logic                            err_o
);
  typedef enum logic [1:0] {IDLE, DRAIN, SWAP} state_e;
  state_e                                  r_state;
  logic [NUM_MAP_RULES-1:0][RULE_W-1:0]    r_shadow;
  logic [NUM_MAP_RULES-1:0][RULE_W-1:0]    r_active;
  logic [CNT_W-1:0]                        r_cnt;
  logic                                    r_rules_valid;
  logic                                    r_err;
  logic                                    r_done;
  logic                                    w_idle;
  logic                                    w_open;
  logic                                    w_inc;
  logic                                    w_slot_ok;
  assign w_idle            = (r_state == IDLE);
  assign w_open            = w_idle & r_rules_valid & (r_cnt < CNT_W'(MAX_OUTSTANDING));
  assign dn_req_o          = up_req_i & w_open;
  assign up_gnt_o          = dn_gnt_i & dn_req_o;
  assign w_inc             = up_gnt_o;
  assign w_slot_ok         = 32'(cfg_rule_idx_i) < NUM_MAP_RULES;
  assign cfg_ready_o       = w_idle;
  assign cfg_commit_done_o = r_done;
  assign rules_o           = r_active;
  assign rules_valid_o     = r_rules_valid;
  assign busy_o            = ~w_idle;
  assign err_o             = r_err;
  // A grant and a response in the same cycle cancel; a lone response at zero is an error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (w_inc && !dn_rvalid_i) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (!w_inc && dn_rvalid_i) begin
      if (r_cnt == '0) r_err <= 1'b1;
      else r_cnt <= r_cnt - 1'b1;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_shadow <= '0;
    else if (cfg_valid_i && cfg_ready_o && w_slot_ok) r_shadow[cfg_rule_idx_i] <= cfg_rule_i;
  end
  // Drain exit looks at the registered count, so the final response lands before the swap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= IDLE;
      r_active      <= '0;
      r_rules_valid <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (cfg_commit_i) r_state <= DRAIN;
        end
        DRAIN: begin
          if (r_cnt == '0) begin
            r_state <= SWAP;
            r_done  <= 1'b1;
          end
        end
        SWAP: begin
          r_active      <= r_shadow;
          r_rules_valid <= 1'b1;
          r_done        <= 1'b0;
          r_state       <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dyn_mem_map_cfg_ctrl.sv
// tb_dyn_mem_map_cfg_ctrl: directed plus randomized stimulus against a transaction-level model,
// with a commit scoreboard drained by an independent monitor on the done pulse.
module tb_dyn_mem_map_cfg_ctrl;
  localparam int N = 4, AW = 32, IW = 2, MAXO = 8;
  localparam int RW = IW + 2 * AW;
  localparam int VW = N * RW;
  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b1;
  logic          cfg_valid_i = 1'b0;
  logic          cfg_ready_o;
  logic [1:0]    cfg_rule_idx_i = '0;
  logic [RW-1:0] cfg_rule_i = '0;
  logic          cfg_commit_i = 1'b0;
  logic          cfg_commit_done_o;
  logic [VW-1:0] rules_o;
  logic          rules_valid_o;
  logic          up_req_i = 1'b0;
  logic          up_gnt_o;
  logic          dn_req_o;
  logic          dn_gnt_i = 1'b0;
  logic          dn_rvalid_i = 1'b0;
  logic          busy_o;
  logic          err_o;
  dyn_mem_map_cfg_ctrl #(.NUM_MAP_RULES(N), .ADDR_WIDTH(AW), .IDX_WIDTH(IW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_rule_idx_i(cfg_rule_idx_i), .cfg_rule_i(cfg_rule_i), .cfg_commit_i(cfg_commit_i),
    .cfg_commit_done_o(cfg_commit_done_o), .rules_o(rules_o), .rules_valid_o(rules_valid_o),
    .up_req_i(up_req_i), .up_gnt_o(up_gnt_o), .dn_req_o(dn_req_o), .dn_gnt_i(dn_gnt_i),
    .dn_rvalid_i(dn_rvalid_i), .busy_o(busy_o), .err_o(err_o));
  always #5 clk_i = ~clk_i;
  int tests = 0, fails = 0;
  logic [VW-1:0] sb_q[$];
  // Model: rule arrays, outstanding as a plain integer, and commit progress flags.
  logic [RW-1:0] m_shadow[N];
  logic [RW-1:0] m_active[N];
  bit m_valid, m_err, m_quiesce, m_swap;
  int m_cnt;
  bit g_last, d_last, mon_pend;
  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [VW-1:0] pack(input logic [RW-1:0] a[N]);
    logic [VW-1:0] v = '0;
    for (int k = 0; k < N; k++) v[k*RW +: RW] = a[k];
    return v;
  endfunction
  function automatic bit gate_open();
    return !m_quiesce && m_valid && (m_cnt < MAXO);
  endfunction
  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_shadow[k] = '0;
      m_active[k] = '0;
    end
    m_valid = 0; m_err = 0; m_quiesce = 0; m_swap = 0; m_cnt = 0;
    sb_q.delete();
  endtask
  task automatic step();
    bit gnt;
    @(negedge clk_i);
    gnt = up_req_i && dn_gnt_i && gate_open();
    chk("dn_req", VW'(dn_req_o), VW'(up_req_i && gate_open()));
    chk("up_gnt", VW'(up_gnt_o), VW'(gnt));
    chk("cfg_ready", VW'(cfg_ready_o), VW'(!m_quiesce));
    chk("busy", VW'(busy_o), VW'(m_quiesce));
    chk("err", VW'(err_o), VW'(m_err));
    chk("done", VW'(cfg_commit_done_o), VW'(m_swap));
    chk("rules_valid", VW'(rules_valid_o), VW'(m_valid));
    chk("rules", rules_o, pack(m_active));
    g_last = up_gnt_o;
    d_last = cfg_commit_done_o;
    @(posedge clk_i);
    if (!m_quiesce && cfg_valid_i && int'(cfg_rule_idx_i) < N) m_shadow[cfg_rule_idx_i] = cfg_rule_i;
    if (m_swap) begin
      for (int k = 0; k < N; k++) m_active[k] = m_shadow[k];
      m_valid = 1; m_quiesce = 0; m_swap = 0;
    end else if (m_quiesce) begin
      if (m_cnt == 0) m_swap = 1;
    end else if (cfg_commit_i) begin
      m_quiesce = 1;
      sb_q.push_back(pack(m_shadow));
    end
    if (gnt && !dn_rvalid_i) m_cnt++;
    else if (!gnt && dn_rvalid_i) begin
      if (m_cnt == 0) m_err = 1;
      else m_cnt--;
    end
    #1;
  endtask
  task automatic drive(input bit req, input bit gnt, input bit rv);
    up_req_i = req; dn_gnt_i = gnt; dn_rvalid_i = rv;
    cfg_valid_i = 0; cfg_commit_i = 0;
  endtask
  task automatic do_reset();
    drive(0, 0, 0);
    rst_ni = 1'b0;
    #2;
    chk("rst_rules", rules_o, '0);
    chk("rst_rules_valid", VW'(rules_valid_o), '0);
    chk("rst_busy", VW'(busy_o), '0);
    chk("rst_done", VW'(cfg_commit_done_o), '0);
    chk("rst_err", VW'(err_o), '0);
    chk("rst_cfg_ready", VW'(cfg_ready_o), VW'(1));
    model_reset();
    #20;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask
  always @(negedge clk_i) begin
    if (!rst_ni) mon_pend = 0;
    else begin
      if (mon_pend) begin
        if (sb_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL commit_sb: got done pulse expected none pending");
        end else begin
          chk("commit_rules", rules_o, sb_q.pop_front());
          chk("commit_valid", VW'(rules_valid_o), VW'(1));
        end
      end
      mon_pend = cfg_commit_done_o;
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    int n, k_done;
    model_reset();
    #1;
    do_reset();
    drive(1, 1, 0);
    repeat (2) step();
    for (int k = 0; k < N; k++) begin
      drive(0, 0, 0);
      cfg_valid_i = 1; cfg_rule_idx_i = 2'(k);
      cfg_rule_i = {2'(k), 32'(k * 32'h1000), 32'((k + 1) * 32'h1000)};
      step();
    end
    drive(0, 0, 0); cfg_commit_i = 1;
    step();
    drive(0, 0, 0);
    k_done = 0;
    for (int k = 1; k <= 3; k++) begin
      step();
      if (d_last && k_done == 0) k_done = k;
    end
    chk("min_latency", VW'(k_done), VW'(2));
    chk("slot1", VW'(rules_o[RW +: RW]), VW'({2'd1, 32'h1000, 32'h2000}));
    drive(1, 1, 0);
    n = 0;
    repeat (12) begin step(); n += int'(g_last); end
    chk("cap_grants", VW'(n), VW'(MAXO));
    drive(1, 1, 1); step();
    drive(1, 1, 0);
    n = 0;
    repeat (3) begin step(); n += int'(g_last); end
    chk("cap_one_more", VW'(n), VW'(1));
    drive(0, 0, 1); repeat (5) step();
    for (int k = 0; k < N; k++) begin
      drive(0, 0, 0);
      cfg_valid_i = 1; cfg_rule_idx_i = 2'(k); cfg_rule_i = RW'({$urandom, $urandom, $urandom});
      step();
    end
    drive(0, 0, 0); cfg_commit_i = 1;
    step();
    k_done = 0;
    for (int k = 1; k <= 12; k++) begin
      drive(1, 1, k == 4 || k == 6 || k == 9);
      step();
      if (d_last && k_done == 0) k_done = k;
      if (k == 12) chk("resume_gnt", VW'(g_last), VW'(1));
    end
    chk("drain_swap_cycle", VW'(k_done), VW'(11));
    drive(1, 1, 0); repeat (4) step();
    drive(1, 1, 1); step();
    drive(1, 1, 0);
    n = 0;
    repeat (5) begin step(); n += int'(g_last); end
    chk("simul_grant_rvalid", VW'(n), VW'(3));
    drive(0, 0, 1); repeat (8) step();
    drive(0, 0, 1); step();
    drive(0, 0, 0); repeat (3) step();
    chk("err_sticky", VW'(err_o), VW'(1));
    drive(1, 1, 0); repeat (2) step();
    drive(0, 0, 0); cfg_commit_i = 1; step();
    drive(0, 0, 0); step();
    chk("drain_busy", VW'(busy_o), VW'(1));
    do_reset();
    drive(0, 0, 0); repeat (4) step();
    drive(0, 0, 0); cfg_commit_i = 1; step();
    drive(0, 0, 0); repeat (4) step();
    repeat (3000) begin
      up_req_i = 1'($urandom);
      dn_gnt_i = 1'($urandom);
      dn_rvalid_i = (m_cnt > 0) && ($urandom_range(0, 2) == 0);
      cfg_valid_i = 1'($urandom);
      cfg_rule_idx_i = 2'($urandom);
      cfg_rule_i = RW'({$urandom, $urandom, $urandom});
      cfg_commit_i = ($urandom_range(0, 29) == 0);
      step();
    end
    for (int i = 0; i < 100 && (m_cnt > 0 || m_quiesce); i++) begin
      drive(0, 0, m_cnt > 0);
      step();
    end
    drive(0, 0, 0); repeat (3) step();
    chk("sb_empty", VW'(sb_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dyn_mem_map_cfg_ctrl.md
Name: dyn_mem_map_cfg_ctrl

Overview:
- Owns the active mapping-rule set that drives the dynamic memory address decoder. Takes rule updates from a config master into shadow registers.
- On commit, it quiesces the upstream TCDM port: it blocks new requests and drains outstanding responses. It then swaps shadow into active atomically, so no in-flight access ever sees a mixed rule set.
- Sits between the core-side TCDM master and the address-map stage. It also caps outstanding transactions.

Parameters:
- NUM_MAP_RULES, 4, number of rule slots.
- ADDR_WIDTH, 32, TCDM address width (rule start/end width).
- IDX_WIDTH, 2, mapping-type index width per rule.
- MAX_OUTSTANDING, 8, maximum granted-but-unanswered requests (>=1).
- RULE_W (derived), IDX_WIDTH+2*ADDR_WIDTH, packed rule {idx, start_addr, end_addr}.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- cfg_valid_i  in  1  shadow rule write request.
- cfg_ready_o  out  1  shadow write accepted when high with cfg_valid_i.
- cfg_rule_idx_i  in  clog2(NUM_MAP_RULES)  rule slot to write.
- cfg_rule_i  in  RULE_W  rule value.
- cfg_commit_i  in  1  request swap shadow->active (single-cycle pulse).
- cfg_commit_done_o  out  1  one-cycle pulse when swap occurs.
- rules_o  out  NUM_MAP_RULES*RULE_W  active rule set to decoder.
- rules_valid_o  out  1  high once at least one commit has completed.
- up_req_i  in  1  upstream TCDM request.
- up_gnt_o  out  1  upstream grant.
- dn_req_o  out  1  downstream request (to address-map stage).
- dn_gnt_i  in  1  downstream grant.
- dn_rvalid_i  in  1  downstream response valid, exactly one per granted request (reads and writes).
- busy_o  out  1  state != IDLE.
- err_o  out  1  sticky: rvalid received with zero outstanding.

Behaviour:
- Reset (async, rst_ni low): state=IDLE; shadow and active rules all zero; outstanding counter=0; rules_valid_o=0, err_o=0, cfg_commit_done_o=0.
- After reset: cfg_ready_o=1 and dn_req_o=0 (rules_valid_o=0).
- Gate open = (state==IDLE) & rules_valid_o & (cnt < MAX_OUTSTANDING).
  - dn_req_o = up_req_i & gate open.
  - up_gnt_o = dn_gnt_i & dn_req_o. Combinational, zero latency.
- Counter cnt, width clog2(MAX_OUTSTANDING+1):
  - +1 on dn_req_o&dn_gnt_i; -1 on dn_rvalid_i.
  - Both in the same cycle: unchanged.
  - rvalid with cnt==0: cnt stays 0 and err_o sets (cleared only by reset).
- Shadow write: on cfg_valid_i & cfg_ready_o, shadow[cfg_rule_idx_i] <= cfg_rule_i.
  - cfg_ready_o = (state==IDLE).
  - Slot index >= NUM_MAP_RULES: write dropped, still handshaked.
- FSM:
  - IDLE: cfg_commit_i -> DRAIN. A shadow write in the same cycle as the commit is included in the swap. A grant in the commit cycle is allowed and counted.
  - DRAIN: gate closed. When cnt==0 -> SWAP. The rvalid that brings cnt to 0 is registered first; exit is evaluated on the registered cnt.
  - SWAP (one cycle): gate closed. cfg_commit_done_o=1. At the end of the cycle, active <= shadow and rules_valid_o <= 1. -> IDLE.
- cfg_commit_i outside IDLE is ignored (no queueing).
- Minimum commit latency with cnt==0:
  - Commit at cycle t, DRAIN at t+1, SWAP at t+2 (done pulse).
  - New rules appear on rules_o from t+3; requests re-enabled at t+3.
- rules_o changes only on the SWAP edge. Never glitches mid-transaction.
- Reset mid-DRAIN/SWAP: returns to IDLE with zeroed rules and rules_valid_o=0. No swap occurs.

Test Plan:
- Reset, then up_req_i=1 -> dn_req_o=0, up_gnt_o=0, cfg_ready_o=1, rules_o=0.
- Write slots 0..3 with {idx=k, start=k*0x1000, end=(k+1)*0x1000}, commit at t with no traffic -> done pulse at t+2; rules_o matches from t+3; rules_valid_o=1.
- MAX_OUTSTANDING=8, downstream grants every cycle, rvalid held off -> exactly 8 grants, then dn_req_o=0. One rvalid -> one further grant.
- 3 outstanding, commit issued -> busy_o=1, no grants. Return rvalids at t+4, t+6, t+9 -> SWAP at t+11, done pulse; traffic resumes at t+12 with new rules.
- Simultaneous grant and rvalid with cnt=5 -> cnt stays 5. rvalid with cnt=0 -> err_o=1, sticky.
- Assert rst_ni low during DRAIN with 2 outstanding -> state IDLE, cnt=0, rules_o=0, rules_valid_o=0. cfg_commit_done_o never pulses.
